// File: rtl/axi_stream_extract_header.sv
// Strips an hdr_len-byte header from each AXI4-Stream packet, emits it on a one-beat header
// channel and realigns the payload to the MSB lane. Optional EXTRACT_ERR_EN adds an err pulse output.
module axi_stream_extract_header #(
   parameter int DATA_WIDTH = 32,
   localparam int DATA_BYTES = DATA_WIDTH / 8,
   localparam int LW = $clog2(DATA_BYTES + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [LW-1:0]         hdr_len,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [DATA_BYTES-1:0] s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [DATA_BYTES-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [DATA_WIDTH-1:0] m_hdr_tdata,
   output logic [DATA_BYTES-1:0] m_hdr_tkeep,
   output logic                  m_hdr_tvalid,
   input  logic                  m_hdr_tready
`ifdef EXTRACT_ERR_EN
   ,
   output logic                  err
`endif
);
   localparam int DB = DATA_BYTES;
   localparam int DW = DATA_WIDTH;

   typedef enum logic [1:0] {FIRST, BODY, FLUSH} state_t;

   function automatic logic [DB-1:0] top_mask(input int n);
      logic [DB-1:0] m;
      m = '0;
      for (int i = 0; i < DB; i++) if (i < n) m[DB-1-i] = 1'b1;
      return m;
   endfunction

   function automatic logic [DW-1:0] byte_mask(input logic [DB-1:0] k);
      logic [DW-1:0] m;
      for (int i = 0; i < DB; i++) m[i*8 +: 8] = {8{k[i]}};
      return m;
   endfunction

   function automatic int keep_cnt(input logic [DB-1:0] k);
      int c;
      c = 0;
      for (int i = 0; i < DB; i++) if (k[i]) c++;
      return c;
   endfunction

   state_t          state_q, state_d;
   logic            run_q;
   logic [LW-1:0]   r_q, r_d;
   logic [DW-1:0]   res_q, res_d;
   logic [DB-1:0]   res_keep_q, res_keep_d;
   logic [DW-1:0]   m_data_q, m_data_d;
   logic [DB-1:0]   m_keep_q, m_keep_d;
   logic            m_valid_q, m_valid_d, m_last_q, m_last_d;
   logic [DW-1:0]   hdr_data_q, hdr_data_d;
   logic [DB-1:0]   hdr_keep_q, hdr_keep_d;
   logic            hdr_valid_q, hdr_valid_d;
   logic            err_d;
   logic            m_free, h_free, s_fire;
   logic [DB-1:0]   k_tmp;
   int              v, h, hn, r, total;

   assign m_free = !m_valid_q || m_axis_tready;
   assign h_free = !hdr_valid_q || m_hdr_tready;
   // Header register only gates the first beat; body beats may overtake a stalled header.
   assign s_axis_tready = run_q && (state_q != FLUSH) && m_free && ((state_q != FIRST) || h_free);
   assign s_fire = s_axis_tvalid && s_axis_tready;

   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      res_d       = res_q;
      res_keep_d  = res_keep_q;
      m_data_d    = m_data_q;
      m_keep_d    = m_keep_q;
      m_last_d    = m_last_q;
      m_valid_d   = m_valid_q && !m_axis_tready;
      hdr_data_d  = hdr_data_q;
      hdr_keep_d  = hdr_keep_q;
      hdr_valid_d = hdr_valid_q && !m_hdr_tready;
      err_d       = 1'b0;
      k_tmp       = '0;
      v           = keep_cnt(s_axis_tkeep);
      h           = (int'(hdr_len) > DB) ? DB : int'(hdr_len);
      hn          = (h < v) ? h : v;
      r           = int'(r_q);
      total       = r + v;
      case (state_q)
         FIRST: if (s_fire) begin
            r_d   = LW'((DB - h) % DB);
            res_d = s_axis_tdata;
            if (h > 0) begin
               hdr_valid_d = 1'b1;
               hdr_keep_d  = top_mask(hn);
               hdr_data_d  = s_axis_tdata & byte_mask(top_mask(hn));
            end
            if (h == 0) begin
               k_tmp     = s_axis_tlast ? s_axis_tkeep : '1;
               m_valid_d = 1'b1;
               m_keep_d  = k_tmp;
               m_data_d  = s_axis_tdata & byte_mask(k_tmp);
               m_last_d  = s_axis_tlast;
            end else if (s_axis_tlast && v > h) begin
               k_tmp     = s_axis_tkeep << h;
               m_valid_d = 1'b1;
               m_keep_d  = k_tmp;
               m_data_d  = (s_axis_tdata << (8 * h)) & byte_mask(k_tmp);
               m_last_d  = 1'b1;
            end
            if (!s_axis_tlast) state_d = BODY;
            err_d = s_axis_tlast ? (v < h) : (s_axis_tkeep != '1);
         end
         BODY: if (s_fire) begin
            // Output = r residual bytes followed by the top bytes of this beat.
            res_d      = s_axis_tdata;
            res_keep_d = s_axis_tkeep;
            m_valid_d  = 1'b1;
            k_tmp      = '1;
            m_last_d   = 1'b0;
            if (s_axis_tlast && total <= DB) begin
               k_tmp    = top_mask(total);
               m_last_d = 1'b1;
               state_d  = FIRST;
            end else if (s_axis_tlast) begin
               state_d = FLUSH;
            end
            m_keep_d = k_tmp;
            m_data_d = ((s_axis_tdata >> (8 * r)) | (res_q << (DW - 8 * r))) & byte_mask(k_tmp);
            err_d    = !s_axis_tlast && (s_axis_tkeep != '1);
         end
         FLUSH: if (m_free) begin
            k_tmp     = res_keep_q << (DB - r);
            m_valid_d = 1'b1;
            m_keep_d  = k_tmp;
            m_data_d  = (res_q << (8 * (DB - r))) & byte_mask(k_tmp);
            m_last_d  = 1'b1;
            state_d   = FIRST;
         end
         default: state_d = FIRST;
      endcase
   end

`ifdef EXTRACT_ERR_EN
   logic err_q;
   always_ff @(posedge clk) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end
   assign err = err_q;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= FIRST;
         run_q       <= 1'b0;
         r_q         <= '0;
         res_q       <= '0;
         res_keep_q  <= '0;
         m_data_q    <= '0;
         m_keep_q    <= '0;
         m_valid_q   <= 1'b0;
         m_last_q    <= 1'b0;
         hdr_data_q  <= '0;
         hdr_keep_q  <= '0;
         hdr_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         run_q       <= 1'b1;
         r_q         <= r_d;
         res_q       <= res_d;
         res_keep_q  <= res_keep_d;
         m_data_q    <= m_data_d;
         m_keep_q    <= m_keep_d;
         m_valid_q   <= m_valid_d;
         m_last_q    <= m_last_d;
         hdr_data_q  <= hdr_data_d;
         hdr_keep_q  <= hdr_keep_d;
         hdr_valid_q <= hdr_valid_d;
      end
   end

   assign m_axis_tdata  = m_data_q;
   assign m_axis_tkeep  = m_keep_q;
   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tlast  = m_last_q;
   assign m_hdr_tdata   = hdr_data_q;
   assign m_hdr_tkeep   = hdr_keep_q;
   assign m_hdr_tvalid  = hdr_valid_q;

   logic unused_err;
   assign unused_err = err_d;
endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Bench for axi_stream_extract_header: spec vectors from a table, a byte-level reference model
// feeding payload/header scoreboards, backpressure and mid-packet reset sequences.
module tb_axi_stream_extract_header;
   localparam int DW = 32;
   localparam int DB = 4;

   logic          clk = 0;
   logic          rst_n = 0;
   logic [2:0]    hdr_len = '0;
   logic [DW-1:0] s_tdata = '0;
   logic [DB-1:0] s_tkeep = '0;
   logic          s_tvalid = 0, s_tlast = 0;
   logic          s_tready;
   logic [DW-1:0] m_tdata, h_tdata;
   logic [DB-1:0] m_tkeep, h_tkeep;
   logic          m_tvalid, m_tlast, h_tvalid;
   logic          m_tready = 1, h_tready = 1;
`ifdef EXTRACT_ERR_EN
   logic          err;
   int            err_seen = 0, err_exp = 0;
`endif

   axi_stream_extract_header #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n), .hdr_len(hdr_len),
      .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
      .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
      .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
      .m_hdr_tdata(h_tdata), .m_hdr_tkeep(h_tkeep), .m_hdr_tvalid(h_tvalid),
      .m_hdr_tready(h_tready)
`ifdef EXTRACT_ERR_EN
      , .err(err)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   logic [36:0] exp_q[$];    // {last, keep, data}
   logic [35:0] hdr_q[$];    // {keep, data}
   logic        chk_en = 1;
   int          rdy_mode = 0; // 0 always, 1 toggle, 2 random
   logic        hdr_hold = 0;
   logic [DW-1:0] bd[8];

   typedef struct {
      int h; int nb; logic [2:0][31:0] d; logic [3:0] klast;
      logic hv; logic [31:0] hd; logic [3:0] hk;
      int np; logic [2:0][31:0] pd; logic [2:0][3:0] pk;
   } vec_t;
   vec_t vt[4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Ready generators update just after the active edge.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: m_tready = 1'b1;
         1: m_tready = ~m_tready;
         default: m_tready = 1'($urandom_range(0, 1));
      endcase
      h_tready = hdr_hold ? 1'b0 : ((rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1);
   end

   // Scoreboard: compare every accepted output beat against the expected queues.
   always @(negedge clk) begin
      if (rst_n && chk_en && m_tvalid && m_tready) begin
         if (exp_q.size() == 0) check("payload_unexpected", {27'd0, m_tlast, m_tkeep, m_tdata}, 64'd0);
         else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            check("payload", {27'd0, m_tlast, m_tkeep, m_tdata}, {27'd0, e});
         end
      end
      if (rst_n && chk_en && h_tvalid && h_tready) begin
         if (hdr_q.size() == 0) check("hdr_unexpected", {28'd0, h_tkeep, h_tdata}, 64'd0);
         else begin
            logic [35:0] e;
            e = hdr_q.pop_front();
            check("hdr", {28'd0, h_tkeep, h_tdata}, {28'd0, e});
         end
      end
`ifdef EXTRACT_ERR_EN
      if (rst_n && chk_en && err) err_seen++;
`endif
   end

   function automatic logic [3:0] top_mask(input int n);
      logic [3:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) if (i < n) m[3-i] = 1'b1;
      return m;
   endfunction

   // Byte-level reference: header = first min(h, beat0 bytes); payload = every byte after h, repacked.
   task automatic model_pkt(input int h, input int nb, input int vlast);
      logic [7:0] bq[$];
      int v0, hn, plen;
      logic [31:0] d;
      logic [3:0] k;
      for (int b = 0; b < nb; b++) begin
         int v;
         v = (b == nb - 1) ? vlast : 4;
         for (int i = 0; i < v; i++) bq.push_back(bd[b][31-8*i -: 8]);
      end
      v0 = (nb == 1) ? vlast : 4;
      hn = (h < v0) ? h : v0;
      if (h > 0) begin
         d = '0;
         for (int i = 0; i < hn; i++) d[31-8*i -: 8] = bq[i];
         hdr_q.push_back({top_mask(hn), d});
      end
`ifdef EXTRACT_ERR_EN
      if (nb == 1 && vlast < h) err_exp++;
`endif
      plen = bq.size() - h;
      for (int i = 0; i < plen; i += 4) begin
         d = '0;
         k = '0;
         for (int j = 0; j < 4 && i + j < plen; j++) begin
            d[31-8*j -: 8] = bq[h+i+j];
            k[3-j] = 1'b1;
         end
         exp_q.push_back({(i + 4 >= plen), k, d});
      end
   endtask

   task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic last);
      int cnt;
      s_tdata = d; s_tkeep = k; s_tlast = last; s_tvalid = 1'b1;
      cnt = 0;
      forever begin
         @(negedge clk);
         if (s_tready) break;
         cnt++;
         if (cnt > 200) begin
            check("s_ready_timeout", 64'd0, 64'd1);
            break;
         end
      end
      @(posedge clk); #1;
      s_tvalid = 1'b0; s_tlast = 1'b0;
   endtask

   task automatic send_pkt(input int h, input int nb, input int vlast);
      hdr_len = 3'(h);
      for (int b = 0; b < nb; b++)
         drive_beat(bd[b], (b == nb - 1) ? top_mask(vlast) : 4'hF, b == nb - 1);
   endtask

   task automatic drain(input string name);
      int cnt;
      cnt = 0;
      while ((exp_q.size() != 0 || hdr_q.size() != 0) && cnt < 300) begin
         @(posedge clk); #1;
         cnt++;
      end
      check(name, {32'd0, 16'(exp_q.size()), 16'(hdr_q.size())}, 64'd0);
   endtask

   initial begin
      vt[0] = '{h: 1, nb: 2, d: {32'h0, 32'h11223344, 32'hAABBCCDD}, klast: 4'hF,
                hv: 1, hd: 32'hAA000000, hk: 4'h8,
                np: 2, pd: {32'h0, 32'h22334400, 32'hBBCCDD11}, pk: {4'h0, 4'hE, 4'hF}};
      vt[1] = '{h: 0, nb: 2, d: {32'h0, 32'h05060000, 32'h01020304}, klast: 4'hC,
                hv: 0, hd: 32'h0, hk: 4'h0,
                np: 2, pd: {32'h0, 32'h05060000, 32'h01020304}, pk: {4'h0, 4'hC, 4'hF}};
      vt[2] = '{h: 4, nb: 2, d: {32'h0, 32'hCAFEF00D, 32'hDEADBEEF}, klast: 4'hF,
                hv: 1, hd: 32'hDEADBEEF, hk: 4'hF,
                np: 1, pd: {32'h0, 32'h0, 32'hCAFEF00D}, pk: {4'h0, 4'h0, 4'hF}};
      vt[3] = '{h: 3, nb: 1, d: {32'h0, 32'h0, 32'h0A0B0C0D}, klast: 4'hF,
                hv: 1, hd: 32'h0A0B0C00, hk: 4'hE,
                np: 1, pd: {32'h0, 32'h0, 32'h0D000000}, pk: {4'h0, 4'h0, 4'h8}};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_m_valid", {63'd0, m_tvalid}, 64'd0);
      check("reset_hdr_valid", {63'd0, h_tvalid}, 64'd0);
      check("reset_s_ready", {63'd0, s_tready}, 64'd0);
      check("reset_m_keep_last", {59'd0, m_tlast, m_tkeep}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Spec vectors from the table
      for (int t = 0; t < 4; t++) begin
         if (vt[t].hv) hdr_q.push_back({vt[t].hk, vt[t].hd});
         for (int p = 0; p < vt[t].np; p++)
            exp_q.push_back({(p == vt[t].np - 1), vt[t].pk[p], vt[t].pd[p]});
         hdr_len = 3'(vt[t].h);
         for (int b = 0; b < vt[t].nb; b++)
            drive_beat(vt[t].d[b], (b == vt[t].nb - 1) ? vt[t].klast : 4'hF, b == vt[t].nb - 1);
      end
      drain("table_drain");

      // Backpressure: h=2, 4 beats, payload ready toggling, header ready held low
      rdy_mode = 1;
      hdr_hold = 1'b1;
      for (int b = 0; b < 4; b++) bd[b] = $urandom;
      model_pkt(2, 4, 4);
      send_pkt(2, 4, 4);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("hdr_pending_valid", {63'd0, h_tvalid}, 64'd1);
      check("hdr_pending_s_ready", {63'd0, s_tready}, 64'd0);
      @(posedge clk); #1;
      hdr_hold = 1'b0;
      drain("backpressure_drain");

      // Random packets under random backpressure on both channels
      rdy_mode = 2;
      for (int n = 0; n < 30; n++) begin
         int h, nb, vl;
         h  = $urandom_range(0, 4);
         nb = $urandom_range(1, 4);
         vl = $urandom_range(1, 4);
         for (int b = 0; b < nb; b++) bd[b] = $urandom;
         model_pkt(h, nb, vl);
         send_pkt(h, nb, vl);
      end
      drain("random_drain");

      // Reset mid-packet after beat 2, outputs discarded
      rdy_mode = 0;
      chk_en = 1'b0;
      for (int b = 0; b < 3; b++) bd[b] = $urandom;
      hdr_len = 3'd2;
      for (int b = 0; b < 3; b++) drive_beat(bd[b], 4'hF, 1'b0);
      rst_n = 1'b0;
      @(posedge clk); @(negedge clk);
      check("midreset_m_valid", {63'd0, m_tvalid}, 64'd0);
      check("midreset_hdr_valid", {63'd0, h_tvalid}, 64'd0);
      check("midreset_s_ready", {63'd0, s_tready}, 64'd0);
      exp_q.delete();
      hdr_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk_en = 1'b1;
      bd[0] = 32'h12345678; bd[1] = 32'h9ABCDEF0;
      model_pkt(1, 2, 3);
      send_pkt(1, 2, 3);
      drain("post_reset_drain");

      // Short header: h=4, single beat keep C
      bd[0] = 32'hA1B2C3D4;
      model_pkt(4, 1, 2);
      send_pkt(4, 1, 2);
      drain("short_hdr_drain");
      repeat (3) @(posedge clk);
`ifdef EXTRACT_ERR_EN
      @(negedge clk);
      check("err_pulses", 64'(err_seen), 64'(err_exp));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
